// File: rtl/clarkpark_inv_pipe_pkg.sv
// ============================================================================
// Package     : clarkpark_pkg
// Description : Shared constants, channel-tag width and rounding/saturation
//               helper for the inverse Park/Clarke pipeline.
//               Macro CLARKPARK_INV_SAT_EN selects clamping instead of wrap.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package clarkpark_pkg;

    localparam int C_IO_WIDTH         = 16;
    localparam int C_IO_DECIMAL_WIDTH = 15;
    localparam int SQRT3DIV2_Q15      = 28378;
    localparam int C_NCH              = 4;

`ifdef CLARKPARK_INV_SAT_EN
    localparam bit C_SAT_EN = 1'b1;
`else
    localparam bit C_SAT_EN = 1'b0;
`endif

    function automatic int ch_width(input int nch);
        return (nch > 1) ? $clog2(nch) : 1;
    endfunction

    // Round half-up by 2^(f-1) then arithmetic shift by f, then fit into w bits
    // either by clamping (sat flagged) or by two's-complement wrap.
    function automatic logic signed [63:0] round_sat(
        input  logic signed [63:0] x,
        input  int                 f,
        input  int                 w,
        input  bit                 sat_en,
        output logic               sat
    );
        logic signed [63:0] r;
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        sat = 1'b0;
        if (f > 0) begin
            r = (x + (64'sd1 <<< (f - 1))) >>> f;
        end else begin
            r = x;
        end
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (w - 1));
        if (sat_en) begin
            if (r > hi) begin
                r   = hi;
                sat = 1'b1;
            end else if (r < lo) begin
                r   = lo;
                sat = 1'b1;
            end
        end else begin
            r = (r <<< (64 - w)) >>> (64 - w);
        end
        return r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/clarkpark_inv_pipe_if.sv
// ============================================================================
// Interface   : clarkpark_inv_pipe_if
// Description : Input and output valid/ready streams of the inverse transform.
//               slave = transform side, master = producer/consumer side.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface clarkpark_inv_pipe_if #(
    parameter int W   = 16,
    parameter int CHW = 2
);
    logic                  is_valid;
    logic                  os_ready;
    logic [CHW-1:0]        ip_ch;
    logic signed [W-1:0]   ip_sine;
    logic signed [W-1:0]   ip_cosine;
    logic signed [W-1:0]   isp_d;
    logic signed [W-1:0]   isp_q;

    logic                  om_valid;
    logic                  im_ready;
    logic [CHW-1:0]        op_ch;
    logic signed [W-1:0]   osp_a;
    logic signed [W-1:0]   osp_b;
    logic signed [W-1:0]   osp_c;
    logic                  op_sat;

    modport slave (
        input  is_valid, ip_ch, ip_sine, ip_cosine, isp_d, isp_q, im_ready,
        output os_ready, om_valid, op_ch, osp_a, osp_b, osp_c, op_sat
    );

    modport master (
        output is_valid, ip_ch, ip_sine, ip_cosine, isp_d, isp_q, im_ready,
        input  os_ready, om_valid, op_ch, osp_a, osp_b, osp_c, op_sat
    );
endinterface

`default_nettype wire

// File: rtl/clarkpark_inv_pipe_fxp_round_sat.sv
// ============================================================================
// Module      : fxp_round_sat
// Description : Combinational round-half-up shifter reducing IN_W to OUT_W bits,
//               clamping when CLARKPARK_INV_SAT_EN is defined, wrapping otherwise.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fxp_round_sat
    import clarkpark_pkg::*;
#(
    parameter int IN_W  = 33,
    parameter int SHIFT = 15,
    parameter int OUT_W = 16
) (
    input  wire logic signed [IN_W-1:0]  din,
    output logic signed [OUT_W-1:0]      dout,
    output logic                         sat
);

    logic signed [63:0] w_full;
    logic               w_sat;

    always_comb begin
        w_sat  = 1'b0;
        w_full = round_sat(64'(din), SHIFT, OUT_W, C_SAT_EN, w_sat);
    end

    assign dout = w_full[OUT_W-1:0];
    assign sat  = w_sat;

    // Upper bits are redundant sign/clamp copies of dout.
    wire w_unused_hi = ^w_full[63:OUT_W];

endmodule

`default_nettype wire

// File: rtl/clarkpark_inv_pipe.sv
// ============================================================================
// Module      : clarkpark_inv_pipe
// Description : Four-stage inverse Park + inverse Clarke (d,q,sin,cos)->(a,b,c)
//               with valid/ready backpressure and a channel tag.
//               Optional clamping via macro CLARKPARK_INV_SAT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module clarkpark_inv_pipe
    import clarkpark_pkg::*;
#(
    parameter int pw_io_width         = C_IO_WIDTH,
    parameter int pw_io_decimal_width = C_IO_DECIMAL_WIDTH,
    parameter int p_sqrt3div2         = SQRT3DIV2_Q15,
    parameter int p_nch               = C_NCH
) (
    input  wire logic              clk,
    input  wire logic              reset,
    clarkpark_inv_pipe_if.slave    bus
);

    localparam int c_w    = pw_io_width;
    localparam int c_w2   = 2 * pw_io_width;
    localparam int c_f    = pw_io_decimal_width;
    localparam int pw_ch  = ch_width(p_nch);
    localparam logic signed [c_w-1:0] c_sqrt3 = c_w'(p_sqrt3div2);
    localparam logic signed [c_w:0]   c_one   = 1;

    // A stall freezes every stage together; a bubble still advances.
    logic w_en;
    assign w_en        = !bus.om_valid || bus.im_ready;
    assign bus.os_ready = w_en;

    // Stage 1: raw products
    logic                    r_v1;
    logic [pw_ch-1:0]        r_ch1;
    logic signed [c_w2-1:0]  r_p_dc, r_p_ds, r_p_qc, r_p_qs;

    // Stage 2: rotated alpha/beta
    logic                    r_v2;
    logic [pw_ch-1:0]        r_ch2;
    logic signed [c_w-1:0]   r_alpha2, r_beta2;
    logic                    r_sat2;

    // Stage 3: alpha, alpha/2, beta*sqrt(3)/2
    logic                    r_v3;
    logic [pw_ch-1:0]        r_ch3;
    logic signed [c_w-1:0]   r_alpha3, r_ah3, r_bs3;
    logic                    r_sat3;

    logic signed [c_w2:0]    w_alpha_full, w_beta_full;
    logic signed [c_w-1:0]   w_alpha, w_beta;
    logic                    w_sat_alpha, w_sat_beta;

    assign w_alpha_full = (c_w2+1)'(r_p_dc) - (c_w2+1)'(r_p_qs);
    assign w_beta_full  = (c_w2+1)'(r_p_ds) + (c_w2+1)'(r_p_qc);

    fxp_round_sat #(.IN_W(c_w2+1), .SHIFT(c_f), .OUT_W(c_w)) u_alpha (
        .din (w_alpha_full),
        .dout(w_alpha),
        .sat (w_sat_alpha)
    );

    fxp_round_sat #(.IN_W(c_w2+1), .SHIFT(c_f), .OUT_W(c_w)) u_beta (
        .din (w_beta_full),
        .dout(w_beta),
        .sat (w_sat_beta)
    );

    logic signed [c_w2-1:0]  w_bs_prod;
    logic signed [c_w-1:0]   w_bs;
    logic                    w_sat_bs;
    logic signed [c_w:0]     w_ah_full;

    assign w_bs_prod = c_w2'(r_beta2) * c_w2'(c_sqrt3);
    // (alpha+1)>>>1 is alpha/2 rounded half-up; always fits back in c_w bits.
    assign w_ah_full = ((c_w+1)'(r_alpha2) + c_one) >>> 1;

    fxp_round_sat #(.IN_W(c_w2), .SHIFT(c_f), .OUT_W(c_w)) u_bs (
        .din (w_bs_prod),
        .dout(w_bs),
        .sat (w_sat_bs)
    );

    logic signed [c_w+1:0]   w_b_full, w_c_full;
    logic signed [c_w-1:0]   w_b, w_c;
    logic                    w_sat_b, w_sat_c;

    assign w_b_full = (c_w+2)'(r_bs3) - (c_w+2)'(r_ah3);
    assign w_c_full = -(c_w+2)'(r_ah3) - (c_w+2)'(r_bs3);

    fxp_round_sat #(.IN_W(c_w+2), .SHIFT(0), .OUT_W(c_w)) u_b (
        .din (w_b_full),
        .dout(w_b),
        .sat (w_sat_b)
    );

    fxp_round_sat #(.IN_W(c_w+2), .SHIFT(0), .OUT_W(c_w)) u_c (
        .din (w_c_full),
        .dout(w_c),
        .sat (w_sat_c)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_v1         <= 1'b0;
            r_v2         <= 1'b0;
            r_v3         <= 1'b0;
            bus.om_valid <= 1'b0;
            r_ch1        <= '0;
            r_ch2        <= '0;
            r_ch3        <= '0;
            r_p_dc       <= '0;
            r_p_ds       <= '0;
            r_p_qc       <= '0;
            r_p_qs       <= '0;
            r_alpha2     <= '0;
            r_beta2      <= '0;
            r_sat2       <= 1'b0;
            r_alpha3     <= '0;
            r_ah3        <= '0;
            r_bs3        <= '0;
            r_sat3       <= 1'b0;
            bus.op_ch    <= '0;
            bus.osp_a    <= '0;
            bus.osp_b    <= '0;
            bus.osp_c    <= '0;
            bus.op_sat   <= 1'b0;
        end else if (w_en) begin
            r_v1         <= bus.is_valid;
            r_v2         <= r_v1;
            r_v3         <= r_v2;
            bus.om_valid <= r_v3;

            r_ch1        <= bus.ip_ch;
            r_p_dc       <= c_w2'(bus.isp_d) * c_w2'(bus.ip_cosine);
            r_p_ds       <= c_w2'(bus.isp_d) * c_w2'(bus.ip_sine);
            r_p_qc       <= c_w2'(bus.isp_q) * c_w2'(bus.ip_cosine);
            r_p_qs       <= c_w2'(bus.isp_q) * c_w2'(bus.ip_sine);

            r_ch2        <= r_ch1;
            r_alpha2     <= w_alpha;
            r_beta2      <= w_beta;
            r_sat2       <= w_sat_alpha | w_sat_beta;

            r_ch3        <= r_ch2;
            r_alpha3     <= r_alpha2;
            r_ah3        <= w_ah_full[c_w-1:0];
            r_bs3        <= w_bs;
            r_sat3       <= r_sat2 | w_sat_bs;

            bus.op_ch    <= r_ch3;
            bus.osp_a    <= r_alpha3;
            bus.osp_b    <= w_b;
            bus.osp_c    <= w_c;
`ifdef CLARKPARK_INV_SAT_EN
            bus.op_sat   <= r_sat3 | w_sat_b | w_sat_c;
`else
            bus.op_sat   <= 1'b0;
`endif
        end
    end

    wire w_unused_ah = w_ah_full[c_w];
`ifndef CLARKPARK_INV_SAT_EN
    wire w_unused_sat = r_sat3 | w_sat_b | w_sat_c;
`endif

endmodule

`default_nettype wire

// File: tb/tb_clarkpark_inv_pipe.sv
// ============================================================================
// Module      : tb_clarkpark_inv_pipe
// Description : Self-checking bench for clarkpark_inv_pipe (either setting of
//               CLARKPARK_INV_SAT_EN) against an arithmetic reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_clarkpark_inv_pipe;

    localparam int W   = 16;
    localparam int CHW = 2;
    localparam longint K3 = 28378;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    clarkpark_inv_pipe_if #(.W(W), .CHW(CHW)) bus ();

    clarkpark_inv_pipe #(
        .pw_io_width(16), .pw_io_decimal_width(15), .p_sqrt3div2(28378), .p_nch(4)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    int checks   = 0;
    int failures = 0;
    int nout     = 0;
    bit rand_ready = 1'b0;

    typedef struct {
        longint a;
        longint b;
        longint c;
        int     ch;
        bit     sat;
    } exp_t;

    exp_t exq[$];
    bit   m_sat;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Round half-up: floor((x + 0.5 LSB) / 2^15).
    function automatic longint rnd(input longint x);
        return (x + 64'sd16384) >>> 15;
    endfunction

    function automatic longint fit(input longint x);
        longint v;
`ifdef CLARKPARK_INV_SAT_EN
        v = x;
        if (x > 32767) begin v = 32767; m_sat = 1'b1; end
        if (x < -32768) begin v = -32768; m_sat = 1'b1; end
`else
        v = x & 64'hFFFF;
        if (v >= 32768) v = v - 65536;
`endif
        return v;
    endfunction

    function automatic exp_t model(input longint d, input longint qv, input longint s,
                                   input longint co, input int ch);
        exp_t   e;
        longint al, be, bs, ah;
        m_sat = 1'b0;
        al    = fit(rnd(d * co - qv * s));
        be    = fit(rnd(d * s + qv * co));
        bs    = fit(rnd(be * K3));
        ah    = (al + 1) >>> 1;
        e.a   = al;
        e.b   = fit(bs - ah);
        e.c   = fit(-ah - bs);
        e.ch  = ch;
        e.sat = m_sat;
        return e;
    endfunction

    // Compare process: observes every handshake mid-cycle, after the drivers.
    initial begin : monitor
        bit     held;
        longint pa, pb, pc;
        int     pch;
        bit     ps;
        exp_t   e;
        held = 1'b0;
        forever begin
            @(negedge clk);
            #1;
            if (reset) begin
                exq.delete();
                held = 1'b0;
            end else begin
                if (held) begin
                    chk("hold_a", bus.osp_a, pa);
                    chk("hold_b", bus.osp_b, pb);
                    chk("hold_c", bus.osp_c, pc);
                    chk("hold_ch", bus.op_ch, pch);
                    chk("hold_sat", bus.op_sat, ps);
                    chk("hold_valid", bus.om_valid, 1);
                end
                chk("os_ready_rule", bus.os_ready, !bus.om_valid || bus.im_ready);
                if (bus.om_valid && bus.im_ready) begin
                    nout++;
                    if (exq.size() == 0) begin
                        chk("unexpected_output", 1, 0);
                    end else begin
                        e = exq.pop_front();
                        chk("out_a", bus.osp_a, e.a);
                        chk("out_b", bus.osp_b, e.b);
                        chk("out_c", bus.osp_c, e.c);
                        chk("out_ch", bus.op_ch, e.ch);
                        chk("out_sat", bus.op_sat, e.sat);
                    end
                end
                if (bus.is_valid && bus.os_ready)
                    exq.push_back(model(bus.isp_d, bus.isp_q, bus.ip_sine, bus.ip_cosine,
                                        int'(bus.ip_ch)));
                held = bus.om_valid && !bus.im_ready;
                pa = bus.osp_a; pb = bus.osp_b; pc = bus.osp_c;
                pch = int'(bus.op_ch); ps = bus.op_sat;
            end
        end
    end

    initial begin : ready_gen
        forever begin
            @(negedge clk);
            if (rand_ready) bus.im_ready = ($urandom_range(0, 99) < 70);
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    // Called at a negedge; returns at the negedge following the accepting edge.
    task automatic send(input int d, input int qv, input int s, input int co, input int ch);
        bit ok;
        bus.is_valid  = 1'b1;
        bus.isp_d     = W'(d);
        bus.isp_q     = W'(qv);
        bus.ip_sine   = W'(s);
        bus.ip_cosine = W'(co);
        bus.ip_ch     = CHW'(ch);
        for (int n = 0; n < 200; n++) begin
            #1;
            ok = bus.os_ready;
            @(negedge clk);
            if (ok) return;
        end
        chk("send_timeout", 0, 1);
    endtask

    task automatic check_reset_state();
        chk("rst_om_valid", bus.om_valid, 0);
        chk("rst_a", bus.osp_a, 0);
        chk("rst_b", bus.osp_b, 0);
        chk("rst_c", bus.osp_c, 0);
        chk("rst_ch", bus.op_ch, 0);
        chk("rst_sat", bus.op_sat, 0);
        chk("rst_os_ready", bus.os_ready, 1);
    endtask

    task automatic lit(input string name, input int d, input int qv, input int s, input int co,
                       input int ch, input int ea, input int eb, input int ec, input int es);
        bus.im_ready = 1'b1;
        send(d, qv, s, co, ch);
        bus.is_valid = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            #1;
            chk({name, "_latency"}, bus.om_valid, 0);
            @(negedge clk);
        end
        #1;
        chk({name, "_valid"}, bus.om_valid, 1);
        chk({name, "_a"}, bus.osp_a, ea);
        chk({name, "_b"}, bus.osp_b, eb);
        chk({name, "_c"}, bus.osp_c, ec);
        chk({name, "_ch"}, bus.op_ch, ch);
        chk({name, "_sat"}, bus.op_sat, es);
        @(negedge clk);
    endtask

    initial begin : main
        int n0;
        int d, qv, s, co;
        real th;
        reset         = 1'b1;
        bus.is_valid  = 1'b0;
        bus.im_ready  = 1'b1;
        bus.isp_d     = '0;
        bus.isp_q     = '0;
        bus.ip_sine   = '0;
        bus.ip_cosine = '0;
        bus.ip_ch     = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        #1;
        check_reset_state();
        @(negedge clk);

        lit("t1", 16384, 0, 0, 32767, 2, 16384, -8192, -8192, 0);
        lit("t2", 0, 16384, 32767, 0, 1, -16383, 8191, 8191, 0);
`ifdef CLARKPARK_INV_SAT_EN
        lit("t3", 32767, 32767, 23170, 23170, 3, 0, 28377, -28377, 1);
`else
        lit("t3", 32767, 32767, 23170, 23170, 3, 0, -16625, 16625, 0);
`endif

        // Backpressure: three back-to-back samples, stall 5 clk once output appears.
        repeat (6) @(negedge clk);
        n0 = nout;
        bus.im_ready = 1'b1;
        send(1000, -2000, 12000, -30000, 0);
        send(-7000, 3000, -20000, 15000, 1);
        send(32000, 32000, 32767, -32768, 2);
        bus.is_valid = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk);
            #1;
            if (bus.om_valid) break;
        end
        bus.im_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            #1;
            chk("stall_os_ready", bus.os_ready, 0);
        end
        @(posedge clk);
        #1;
        bus.im_ready = 1'b1;
        repeat (8) @(negedge clk);
        chk("stall_count", nout - n0, 3);

        // Reset with two samples in flight.
        send(5000, 6000, 7000, 8000, 3);
        send(-5000, -6000, -7000, -8000, 2);
        bus.is_valid = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        check_reset_state();
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            #1;
            chk("no_stale", bus.om_valid, 0);
        end
        @(negedge clk);

        // Randomized stream with random gaps and backpressure.
        rand_ready = 1'b1;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                bus.is_valid = 1'b0;
                @(negedge clk);
            end
            d  = int'($urandom_range(0, 65535)) - 32768;
            qv = int'($urandom_range(0, 65535)) - 32768;
            if ($urandom_range(0, 7) == 0) begin
                s  = int'($urandom_range(0, 65535)) - 32768;
                co = int'($urandom_range(0, 65535)) - 32768;
            end else begin
                th = real'($urandom_range(0, 3599)) * 3.14159265358979 / 1800.0;
                s  = int'(32767.0 * $sin(th));
                co = int'(32767.0 * $cos(th));
            end
            send(d, qv, s, co, int'($urandom_range(0, 3)));
        end
        bus.is_valid = 1'b0;
        rand_ready = 1'b0;
        @(negedge clk);
        bus.im_ready = 1'b1;
        for (int k = 0; k < 30 && exq.size() != 0; k++) @(negedge clk);
        #2;
        chk("drain_empty", exq.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
